csr_access_ctrl: RTL and testbench
==================================

Name: csr_access_ctrl

Overview:
Sequences RISC-V Zicsr instructions (CSRRW/S/C and immediate forms) as read-modify-write operations against the 8-entry machine CSR register file. Arbitrates the file's single access port between the execute-stage CSR instruction port and the trap unit's direct-write port. Sits between execute/trap logic and the CSR file; the file has a registered read with 1-cycle latency.

Parameters:
NUM_CSR, 8, number of implemented CSRs; legal index range is 0..NUM_CSR-1.
XLEN, 32, data width.
RO_MASK, 8'h00, bit i=1 marks CSR i read-only.

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-low reset
instr_valid  in  1  CSR instruction request
instr_ready  out  1  controller accepts instruction this cycle
instr_op  in  3  funct3: 001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI
instr_addr  in  12  CSR address
instr_src  in  XLEN  rs1 value; for immediate ops, bits [4:0] are zimm
instr_rs1_zero  in  1  rs1 field is x0 (register forms only)
resp_valid  out  1  one-cycle response pulse
resp_rdata  out  XLEN  old CSR value, written to rd
resp_illegal  out  1  illegal-instruction flag, valid with resp_valid
trap_valid  in  1  trap-unit direct write request
trap_ready  out  1  trap write accepted
trap_idx  in  3  CSR index
trap_wdata  in  XLEN  value to write
csr_en  out  1  CSR file access strobe
csr_we  out  1  write enable, qualified by csr_en
csr_idx  out  3  CSR file index
csr_wdata  out  XLEN  write data
csr_rdata  in  XLEN  read data, valid the cycle after a read strobe
busy  out  1  FSM not in IDLE

Behaviour:
- Reset (reset==0 at a clk edge): state goes to IDLE. All outputs are 0 except instr_ready/trap_ready, which follow the IDLE rules. An in-flight op is dropped: no write and no response.
- States: IDLE, RD, WB, TRAP, ERR.
- Arbitration in IDLE: trap has priority.
  - trap_ready = 1 in IDLE.
  - instr_ready = 1 in IDLE when trap_valid==0.
  - Both are 0 in all other states.
- Trap path: accept edge -> TRAP. In TRAP: csr_en=1, csr_we=1, csr_idx/csr_wdata come from captured trap_idx/trap_wdata. TRAP always returns to IDLE; no response is generated. trap_idx >= NUM_CSR: the write is dropped (csr_en=0), no error.
- Instruction accept: capture op, addr, src and rs1_zero.
  - Illegal if any of: op is 000 or 100; addr >= NUM_CSR; a write-intending op targets an RO_MASK CSR.
  - Write intent: RW/RWI always. RS/RC: when rs1_zero==0. RSI/RCI: when zimm!=0.
  - Illegal -> ERR; legal -> RD.
- RD: csr_en=1, csr_we=0, csr_idx=addr[2:0]. Next state WB.
- WB: old = csr_rdata.
  - Operand: instr_src for register ops; zero-extended zimm for immediate ops.
  - New value: RW = operand; RS = old | operand; RC = old & ~operand.
  - If write intent: csr_en=1, csr_we=1, csr_wdata = new value. Otherwise csr_en=0.
  - resp_valid=1, resp_rdata=old, resp_illegal=0.
  - Next state IDLE.
- ERR: resp_valid=1, resp_illegal=1, resp_rdata=0, no CSR access. Next state IDLE.
- Latency: accept at edge T0; read in cycle T0+1; write and response in cycle T0+2. A new accept is possible at the T0+3 edge, so throughput is 1 instruction per 3 cycles.
- resp_valid is a single-cycle pulse with no backpressure; the consumer must sample it.
- Outputs in states that do not drive them: resp_* = 0; csr_wdata/csr_idx hold their last value, with csr_en=0.
- Simultaneous trap_valid and instr_valid in IDLE: trap wins. The instruction waits with instr_ready=0 and must hold its inputs stable.
- Write-back ordering: the WB write commits at the edge ending WB. A trap accepted at the next IDLE cycle therefore overwrites it.

Decomposition:
- Shared package csr_ctrl_pkg contains:
  - funct3 op encoding constants;
  - the state enum (IDLE, RD, WB, TRAP, ERR);
  - a CSR index width constant (3);
  - a function that decodes write intent.
- One natural sub-module: csr_rmw_alu. It is combinational and maps op, old value, operand and zimm to new value and write-enable. It is unit-testable on its own.

Test Plan:
- CSRRW addr 2, src 0xDEADBEEF, CSR2=0x11 -> resp_rdata 0x11 at T0+2; CSR2=0xDEADBEEF afterwards; csr_we high exactly one cycle.
- CSRRS addr 1, rs1_zero=1, CSR1=0xF0 -> resp_rdata 0xF0; csr_we never asserted. Then CSRRCI addr 1, zimm 0x10 -> CSR1=0xE0.
- Illegal cases: addr 9; op 100; CSRRW to a CSR with RO_MASK bit set -> resp_illegal=1, resp_rdata 0, csr_en never high, response at T0+1.
- trap_valid and instr_valid asserted in the same cycle, trap_idx 3, wdata 0xA5 -> TRAP write first, instr_ready=0. The instruction is then accepted and completes; response appears 4 cycles after the first valid.
- Reset low during WB of a CSRRW -> no resp_valid and no write of the new value; busy=0 after the edge; first post-reset request completes normally.
- Back-to-back RS to the same addr with src 0x1 then 0x2, CSR=0 -> responses 0x0 then 0x1; final value 0x3.

Source files
------------

// File: rtl/csr_ctrl_pkg.sv
// Shared definitions for the CSR access controller: funct3 encodings, FSM
// state codes and the write-intent / index-range helpers.
package csr_ctrl_pkg;

   localparam int CSR_IDX_W = 3;

   localparam logic [2:0] OP_RW  = 3'b001;
   localparam logic [2:0] OP_RS  = 3'b010;
   localparam logic [2:0] OP_RC  = 3'b011;
   localparam logic [2:0] OP_RWI = 3'b101;
   localparam logic [2:0] OP_RSI = 3'b110;
   localparam logic [2:0] OP_RCI = 3'b111;

   typedef logic [2:0] csr_state_t;

   localparam csr_state_t S_IDLE = 3'd0;
   localparam csr_state_t S_RD   = 3'd1;
   localparam csr_state_t S_WB   = 3'd2;
   localparam csr_state_t S_TRAP = 3'd3;
   localparam csr_state_t S_ERR  = 3'd4;

   // Set/clear forms only write when they can change something: rs1 != x0 or zimm != 0.
   function automatic logic write_intent(input logic [2:0] op,
                                         input logic       rs1_zero,
                                         input logic [4:0] zimm);
      case (op)
         OP_RW, OP_RWI:  return 1'b1;
         OP_RS, OP_RC:   return !rs1_zero;
         OP_RSI, OP_RCI: return zimm != 5'd0;
         default:        return 1'b0;
      endcase
   endfunction

   function automatic logic idx_in_range(input logic [31:0] idx, input int unsigned num);
      return idx < num;
   endfunction

endpackage

// File: rtl/csr_rmw_alu.sv
// Combinational read-modify-write datapath: new CSR value and write enable
// from the funct3 op, the old value and the rs1/zimm source.
module csr_rmw_alu
   import csr_ctrl_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  logic [2:0]      op,
   input  logic            rs1_zero,
   input  logic [XLEN-1:0] old_val,
   input  logic [XLEN-1:0] src,
   output logic [XLEN-1:0] new_val,
   output logic            wr_en
);

   logic [XLEN-1:0] operand;

   // NOTE: every variable written in always_comb gets a default first, so no path can infer a latch.
   always_comb begin
      operand = op[2] ? XLEN'(src[4:0]) : src;
      new_val = old_val;
      case (op[1:0])
         2'b01:   new_val = operand;
         2'b10:   new_val = old_val | operand;
         2'b11:   new_val = old_val & ~operand;
         default: new_val = old_val;
      endcase
      wr_en = write_intent(op, rs1_zero, src[4:0]);
   end

endmodule

// File: rtl/csr_access_ctrl.sv
// Zicsr read-modify-write sequencer arbitrating the CSR file port between
// execute-stage CSR instructions and trap-unit direct writes (trap wins).
module csr_access_ctrl
   import csr_ctrl_pkg::*;
#(
   parameter int unsigned        NUM_CSR = 8,
   parameter int unsigned        XLEN    = 32,
   parameter logic [NUM_CSR-1:0] RO_MASK = 8'h00
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 instr_valid,
   output logic                 instr_ready,
   input  logic [2:0]           instr_op,
   input  logic [11:0]          instr_addr,
   input  logic [XLEN-1:0]      instr_src,
   input  logic                 instr_rs1_zero,
   output logic                 resp_valid,
   output logic [XLEN-1:0]      resp_rdata,
   output logic                 resp_illegal,
   input  logic                 trap_valid,
   output logic                 trap_ready,
   input  logic [CSR_IDX_W-1:0] trap_idx,
   input  logic [XLEN-1:0]      trap_wdata,
   output logic                 csr_en,
   output logic                 csr_we,
   output logic [CSR_IDX_W-1:0] csr_idx,
   output logic [XLEN-1:0]      csr_wdata,
   input  logic [XLEN-1:0]      csr_rdata,
   output logic                 busy
);

   csr_state_t           state_q, state_d;
   logic [2:0]           op_q;
   logic [CSR_IDX_W-1:0] addr_q;
   logic [XLEN-1:0]      src_q;
   logic                 rs1_zero_q;
   logic [CSR_IDX_W-1:0] trap_idx_q;
   logic [XLEN-1:0]      trap_wdata_q;
   logic                 trap_legal_q;
   logic [CSR_IDX_W-1:0] idx_hold_q, idx_d;
   logic [XLEN-1:0]      wdata_hold_q, wdata_d;

   logic                 en_d, we_d, resp_v_d, resp_ill_d;
   logic [XLEN-1:0]      resp_rdata_d;
   logic                 instr_illegal;
   logic                 instr_wi;
   logic [XLEN-1:0]      alu_new;
   logic                 alu_we;

   csr_rmw_alu #(.XLEN(XLEN)) u_alu (
      .op       (op_q),
      .rs1_zero (rs1_zero_q),
      .old_val  (csr_rdata),
      .src      (src_q),
      .new_val  (alu_new),
      .wr_en    (alu_we)
   );

   always_comb begin
      instr_wi      = write_intent(instr_op, instr_rs1_zero, instr_src[4:0]);
      instr_illegal = (instr_op == 3'b000) || (instr_op == 3'b100)
                   || !idx_in_range({20'd0, instr_addr}, NUM_CSR)
                   || (instr_wi && RO_MASK[instr_addr[CSR_IDX_W-1:0]]);
   end

   always_comb begin
      trap_ready   = (state_q == S_IDLE);
      instr_ready  = (state_q == S_IDLE) && !trap_valid;
      state_d      = state_q;
      en_d         = 1'b0;
      we_d         = 1'b0;
      idx_d        = idx_hold_q;
      wdata_d      = wdata_hold_q;
      resp_v_d     = 1'b0;
      resp_ill_d   = 1'b0;
      resp_rdata_d = '0;
      case (state_q)
         S_IDLE: begin
            if (trap_valid)       state_d = S_TRAP;
            else if (instr_valid) state_d = instr_illegal ? S_ERR : S_RD;
         end
         S_RD: begin
            en_d    = 1'b1;
            idx_d   = addr_q;
            state_d = S_WB;
         end
         S_WB: begin
            en_d         = alu_we;
            we_d         = alu_we;
            if (alu_we) begin
               idx_d   = addr_q;
               wdata_d = alu_new;
            end
            resp_v_d     = 1'b1;
            resp_rdata_d = csr_rdata;
            state_d      = S_IDLE;
         end
         S_TRAP: begin
            en_d = trap_legal_q;
            we_d = 1'b1;
            if (trap_legal_q) begin
               idx_d   = trap_idx_q;
               wdata_d = trap_wdata_q;
            end
            state_d = S_IDLE;
         end
         S_ERR: begin
            resp_v_d   = 1'b1;
            resp_ill_d = 1'b1;
            state_d    = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // A cycle with reset low must not commit a write or emit a response for the dropped op.
   assign csr_en       = reset && en_d;
   assign csr_we       = reset && we_d;
   assign csr_idx      = idx_d;
   assign csr_wdata    = wdata_d;
   assign resp_valid   = reset && resp_v_d;
   assign resp_illegal = reset && resp_ill_d;
   assign resp_rdata   = reset ? resp_rdata_d : '0;
   assign busy         = (state_q != S_IDLE);

   // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q      <= S_IDLE;
         op_q         <= '0;
         addr_q       <= '0;
         src_q        <= '0;
         rs1_zero_q   <= 1'b0;
         trap_idx_q   <= '0;
         trap_wdata_q <= '0;
         trap_legal_q <= 1'b0;
         idx_hold_q   <= '0;
         wdata_hold_q <= '0;
      end else begin
         state_q      <= state_d;
         idx_hold_q   <= idx_d;
         wdata_hold_q <= wdata_d;
         if (trap_ready && trap_valid) begin
            trap_idx_q   <= trap_idx;
            trap_wdata_q <= trap_wdata;
            trap_legal_q <= idx_in_range({{(32-CSR_IDX_W){1'b0}}, trap_idx}, NUM_CSR);
         end else if (instr_ready && instr_valid) begin
            op_q       <= instr_op;
            addr_q     <= instr_addr[CSR_IDX_W-1:0];
            src_q      <= instr_src;
            rs1_zero_q <= instr_rs1_zero;
         end
      end
   end

endmodule

// File: tb/tb_csr_access_ctrl.sv
// Self-checking bench for csr_access_ctrl: directed scenarios plus random
// instruction/trap traffic against a behavioural CSR model.
module tb_csr_access_ctrl;

   localparam logic [7:0] RO = 8'h80;

   logic        clk = 1'b0;
   logic        reset;
   logic        instr_valid;
   logic        instr_ready;
   logic [2:0]  instr_op;
   logic [11:0] instr_addr;
   logic [31:0] instr_src;
   logic        instr_rs1_zero;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_illegal;
   logic        trap_valid;
   logic        trap_ready;
   logic [2:0]  trap_idx;
   logic [31:0] trap_wdata;
   logic        csr_en;
   logic        csr_we;
   logic [2:0]  csr_idx;
   logic [31:0] csr_wdata;
   logic [31:0] csr_rdata = '0;
   logic        busy;

   logic [31:0] csr_mem [8];
   logic [31:0] model [8];
   int          wr_cnt = 0;
   int          n_checks = 0;
   int          n_fail = 0;

   always #5 clk = ~clk;

   csr_access_ctrl #(.NUM_CSR(8), .XLEN(32), .RO_MASK(RO)) dut (
      .clk            (clk),
      .reset          (reset),
      .instr_valid    (instr_valid),
      .instr_ready    (instr_ready),
      .instr_op       (instr_op),
      .instr_addr     (instr_addr),
      .instr_src      (instr_src),
      .instr_rs1_zero (instr_rs1_zero),
      .resp_valid     (resp_valid),
      .resp_rdata     (resp_rdata),
      .resp_illegal   (resp_illegal),
      .trap_valid     (trap_valid),
      .trap_ready     (trap_ready),
      .trap_idx       (trap_idx),
      .trap_wdata     (trap_wdata),
      .csr_en         (csr_en),
      .csr_we         (csr_we),
      .csr_idx        (csr_idx),
      .csr_wdata      (csr_wdata),
      .csr_rdata      (csr_rdata),
      .busy           (busy)
   );

   // CSR file with registered read, one-cycle latency
   always @(posedge clk) begin
      if (csr_en && csr_we) begin
         csr_mem[csr_idx] <= csr_wdata;
         wr_cnt           <= wr_cnt + 1;
      end
      if (csr_en && !csr_we) csr_rdata <= csr_mem[csr_idx];
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
      end
   endtask

   function automatic void predict(input logic [2:0] op, input logic [11:0] addr,
                                   input logic [31:0] src, input logic rs1z,
                                   output logic ill, output logic wi,
                                   output logic [31:0] old_v, output logic [31:0] new_v);
      logic        is_imm;
      logic [31:0] opnd;
      int          kind;
      is_imm = (op >= 3'd5);
      kind   = int'(op) % 4;
      opnd   = is_imm ? (src % 32) : src;
      if (kind == 1)      wi = 1'b1;
      else if (is_imm)    wi = (src % 32) != 0;
      else                wi = !rs1z;
      ill    = (op == 3'd0) || (op == 3'd4) || (addr > 12'd7) || (wi && RO[addr % 8]);
      old_v  = model[addr % 8];
      case (kind)
         1:       new_v = opnd;
         2:       new_v = old_v | opnd;
         3:       new_v = old_v & ~opnd;
         default: new_v = old_v;
      endcase
   endfunction

   task automatic do_instr(input logic [2:0] op, input logic [11:0] addr,
                           input logic [31:0] src, input logic rs1z);
      logic        ill, wi;
      logic [31:0] old_v, new_v;
      int          w0, waited;
      predict(op, addr, src, rs1z, ill, wi, old_v, new_v);
      @(posedge clk); #1;
      instr_valid = 1'b1; instr_op = op; instr_addr = addr;
      instr_src = src; instr_rs1_zero = rs1z;
      waited = 0;
      @(negedge clk);
      while (!instr_ready && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      check("instr_ready", 32'(instr_ready), 32'd1);
      w0 = wr_cnt;
      @(posedge clk); #1;
      instr_valid = 1'b0;
      @(negedge clk);
      if (ill) begin
         check("err_resp_valid", 32'(resp_valid), 32'd1);
         check("err_illegal", 32'(resp_illegal), 32'd1);
         check("err_rdata", resp_rdata, 32'd0);
         check("err_csr_en", 32'(csr_en), 32'd0);
      end else begin
         check("rd_en", 32'(csr_en), 32'd1);
         check("rd_we", 32'(csr_we), 32'd0);
         check("rd_idx", 32'(csr_idx), 32'(addr % 8));
         check("rd_resp", 32'(resp_valid), 32'd0);
         @(negedge clk);
         check("wb_resp_valid", 32'(resp_valid), 32'd1);
         check("wb_illegal", 32'(resp_illegal), 32'd0);
         check("wb_rdata", resp_rdata, old_v);
         check("wb_en", 32'(csr_en), 32'(wi));
         if (wi) begin
            check("wb_wdata", csr_wdata, new_v);
            model[addr % 8] = new_v;
         end
      end
      @(negedge clk);
      check("busy_after", 32'(busy), 32'd0);
      check("resp_after", 32'(resp_valid), 32'd0);
      check("wr_count", 32'(wr_cnt - w0), (wi && !ill) ? 32'd1 : 32'd0);
      check("csr_value", csr_mem[addr % 8], model[addr % 8]);
   endtask

   task automatic do_trap(input logic [2:0] idx, input logic [31:0] wd);
      int w0;
      @(posedge clk); #1;
      trap_valid = 1'b1; trap_idx = idx; trap_wdata = wd;
      @(negedge clk);
      check("trap_ready", 32'(trap_ready), 32'd1);
      w0 = wr_cnt;
      @(posedge clk); #1;
      trap_valid = 1'b0;
      @(negedge clk);
      check("trap_en", 32'(csr_en), 32'd1);
      check("trap_we", 32'(csr_we), 32'd1);
      check("trap_idx", 32'(csr_idx), 32'(idx));
      check("trap_wdata", csr_wdata, wd);
      check("trap_no_resp", 32'(resp_valid), 32'd0);
      model[idx] = wd;
      @(negedge clk);
      check("trap_busy_after", 32'(busy), 32'd0);
      check("trap_wr_count", 32'(wr_cnt - w0), 32'd1);
      check("trap_value", csr_mem[idx], model[idx]);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 8; i++) model[i] = '0;
      reset = 1'b0; instr_valid = 1'b0; instr_op = '0; instr_addr = '0;
      instr_src = '0; instr_rs1_zero = 1'b0; trap_valid = 1'b0;
      trap_idx = '0; trap_wdata = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_csr_en", 32'(csr_en), 32'd0);
      check("rst_csr_we", 32'(csr_we), 32'd0);
      check("rst_resp_valid", 32'(resp_valid), 32'd0);
      check("rst_resp_illegal", 32'(resp_illegal), 32'd0);
      check("rst_resp_rdata", resp_rdata, 32'd0);
      check("rst_csr_idx", 32'(csr_idx), 32'd0);
      check("rst_csr_wdata", csr_wdata, 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_trap_ready", 32'(trap_ready), 32'd1);
      check("rst_instr_ready", 32'(instr_ready), 32'd1);
      @(posedge clk); #1;
      reset = 1'b1;

      for (int i = 0; i < 8; i++) do_trap(3'(i), $urandom);
      do_trap(3'd2, 32'h11);
      do_trap(3'd1, 32'hF0);
      do_trap(3'd4, 32'h0);

      // CSRRW, CSRRS with x0, CSRRCI
      do_instr(3'b001, 12'd2, 32'hDEADBEEF, 1'b0);
      check("csr2_final", csr_mem[2], 32'hDEADBEEF);
      do_instr(3'b010, 12'd1, 32'h0, 1'b1);
      do_instr(3'b111, 12'd1, 32'h10, 1'b0);
      check("csr1_final", csr_mem[1], 32'hE0);

      // illegal: out-of-range address, reserved op, write to read-only CSR
      do_instr(3'b001, 12'd9, 32'h5, 1'b0);
      do_instr(3'b100, 12'd3, 32'h5, 1'b0);
      do_instr(3'b001, 12'd7, 32'h5, 1'b0);
      do_instr(3'b010, 12'd7, 32'h0, 1'b1);

      // back-to-back set-bits on a zeroed CSR
      do_instr(3'b010, 12'd4, 32'h1, 1'b0);
      do_instr(3'b010, 12'd4, 32'h2, 1'b0);
      check("csr4_final", csr_mem[4], 32'h3);

      // simultaneous trap and instruction: trap goes first
      @(posedge clk); #1;
      trap_valid = 1'b1; trap_idx = 3'd3; trap_wdata = 32'hA5;
      instr_valid = 1'b1; instr_op = 3'b001; instr_addr = 12'd3;
      instr_src = 32'h1234; instr_rs1_zero = 1'b0;
      @(negedge clk);
      check("sim_trap_ready", 32'(trap_ready), 32'd1);
      check("sim_instr_ready0", 32'(instr_ready), 32'd0);
      @(posedge clk); #1;
      trap_valid = 1'b0;
      @(negedge clk);
      check("sim_trap_we", 32'(csr_en && csr_we), 32'd1);
      check("sim_trap_wdata", csr_wdata, 32'hA5);
      check("sim_instr_ready1", 32'(instr_ready), 32'd0);
      @(negedge clk);
      check("sim_instr_ready2", 32'(instr_ready), 32'd1);
      @(posedge clk); #1;
      instr_valid = 1'b0;
      @(negedge clk);
      check("sim_rd_resp", 32'(resp_valid), 32'd0);
      @(negedge clk);
      check("sim_resp_valid", 32'(resp_valid), 32'd1);
      check("sim_resp_rdata", resp_rdata, 32'hA5);
      @(negedge clk);
      model[3] = 32'h1234;
      check("sim_csr3", csr_mem[3], model[3]);

      // reset asserted during write-back drops the op
      @(posedge clk); #1;
      instr_valid = 1'b1; instr_op = 3'b001; instr_addr = 12'd5;
      instr_src = 32'hCAFEF00D; instr_rs1_zero = 1'b0;
      @(negedge clk);
      check("rstwb_ready", 32'(instr_ready), 32'd1);
      @(posedge clk); #1;
      instr_valid = 1'b0;
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      check("rstwb_resp", 32'(resp_valid), 32'd0);
      check("rstwb_we", 32'(csr_en && csr_we), 32'd0);
      @(posedge clk); #1;
      reset = 1'b1;
      @(negedge clk);
      check("rstwb_busy", 32'(busy), 32'd0);
      check("rstwb_csr5", csr_mem[5], model[5]);
      do_instr(3'b010, 12'd5, 32'h0, 1'b1);

      // random traffic
      for (int n = 0; n < 150; n++) begin
         if ($urandom_range(0, 4) == 0) begin
            do_trap(3'($urandom_range(0, 7)), $urandom);
         end else begin
            do_instr(3'($urandom_range(0, 7)),
                     ($urandom_range(0, 5) == 0) ? 12'($urandom_range(0, 4095))
                                                 : 12'($urandom_range(0, 7)),
                     ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 31)) : $urandom,
                     1'($urandom_range(0, 1)));
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
